store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer on the data-memory side of the single-cycle core: sits between the core's
//  memwrite/aluout/writedata/readdata bus and a data memory with a handshaked write port.
//  Core stores retire in one cycle into a FIFO, which drains to memory in order as mem_wack allows.
//  Loads read memory through an async port; a hit on a pending store is forwarded (youngest wins).
//  stall tells the core's PC/regfile enables to hold when the buffer is full.
// PARAMETERS
//  DEPTH  4   entries; power of two, >= 2
//  DW     32  data width
//  AW     32  byte-address width; word compare on [AW-1:2]
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-low reset
//  memwrite   in   1              core store strobe
//  aluout     in   AW             core load/store byte address
//  writedata  in   DW             core store data
//  readdata   out  DW             load data to core (combinational)
//  stall      out  1              buffer full; core must hold the store
//  mem_raddr  out  AW             async read address = aluout
//  mem_rdata  in   DW             async read data from memory
//  mem_wreq   out  1              head entry valid, write requested
//  mem_waddr  out  AW             head entry address
//  mem_wdata  out  DW             head entry data
//  mem_wack   in   1              memory accepts head write at this posedge
//  count      out  clog2(DEPTH)+1 occupied entries
// BEHAVIOUR
//  Reset (rst=0, async): all entries invalid, wr_ptr=rd_ptr=0, count=0. mem_wreq=0 and stall=0 immediately.
//  readdata follows the async memory read/forward path (mem_rdata when no hit). mem_waddr/mem_wdata are 0.
//  Push: at posedge when memwrite=1 and count<DEPTH: write {aluout,writedata} at wr_ptr, wr_ptr+1 mod DEPTH.
//  stall = (count==DEPTH); decoded from registered count, not from mem_wack.
//  memwrite while full is dropped; the core holds the store while stall=1, so it is re-presented.
//  Pop: mem_wreq = (count!=0). mem_waddr/mem_wdata = head entry, stable while mem_wreq=1.
//  On posedge with mem_wreq=1 and mem_wack=1: rd_ptr+1 mod DEPTH, count-1.
//  mem_wack while mem_wreq=0: ignored.
//  Push+pop same edge: count unchanged; both pointers advance.
//  Full+ack+memwrite same edge: pop only (stall was 1); the push is taken next cycle.
//  Writes reach memory strictly in push order; no merging (same-address stores each occupy an entry).
//  Forwarding: mem_raddr=aluout. Compare aluout[AW-1:2] against every valid entry.
//  On any hit, readdata = data of the youngest matching entry (closest to wr_ptr), else mem_rdata.
//  Entry being popped this cycle still counts as valid.
//  A store being pushed this cycle does not forward; single-cycle core never loads and stores at once.
//  Pointers wrap modulo DEPTH; count distinguishes full from empty (ptr equality).
//  Reset mid-drain: pending stores are discarded; mem_wreq falls asynchronously. The memory must tolerate an abandoned request.
//  No X on outputs after reset; mem_wdata/mem_waddr = 0 when empty.
// TESTING
//  1 Reset: assert rst=0 mid-cycle -> mem_wreq=0, stall=0, count=0 immediately; readdata==mem_rdata.
//  2 Single store: memwrite addr 0x10 data 0xDEADBEEF; mem_wack high 3 cycles later
//    -> wreq held 3 cycles with stable addr/data, count 1->0 after ack edge.
//  3 Fill: 4 stores 0x0/0x4/0x8/0xC, no ack -> count=4, stall=1.
//    5th store (0x20) dropped; one ack -> stall=0; re-presented 0x20 accepted.
//    Memory sees 0x0,0x4,0x8,0xC,0x20 in order.
//  4 Forward: stores 0x40<-0x11, 0x44<-0x22, 0x40<-0x33 pending, mem_rdata=0x99.
//    Load 0x40 -> 0x33; load 0x42 -> 0x33 (word match); load 0x48 -> 0x99.
//  5 Push+pop: count=2, memwrite and mem_wack on same edge -> count stays 2; FIFO order preserved.
//    Repeat across pointer wrap, >=2*DEPTH stores.
//  6 Reset mid-drain: 3 pending, wreq=1, pulse rst=0 -> wreq drops at once, count=0.
//    No write issued for discarded entries after release.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write FIFO between core and data memory, with youngest-wins load forwarding.
// Ports: core side (memwrite/aluout/writedata/readdata/stall), memory side (mem_*), count.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memwrite,
  input  logic [AW-1:0]              aluout,
  input  logic [DW-1:0]              writedata,
  output logic [DW-1:0]              readdata,
  output logic                       stall,
  output logic [AW-1:0]              mem_raddr,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       mem_wreq,
  output logic [AW-1:0]              mem_waddr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_wack,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  logic push;
  logic pop;
  logic full;

  assign full     = (cnt_q == CW'(DEPTH));
  assign stall    = full;
  assign mem_wreq = (cnt_q != '0);
  assign push     = memwrite && !full;
  assign pop      = mem_wreq && mem_wack;
  assign count    = cnt_q;

  assign mem_raddr = aluout;
  assign mem_waddr = mem_wreq ? addr_q[rd_ptr] : '0;
  assign mem_wdata = mem_wreq ? data_q[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= aluout;
        data_q[wr_ptr] <= writedata;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < cnt_q &&
          addr_q[idx][AW-1:2] == aluout[AW-1:2]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign readdata = fwd_hit ? fwd_data : mem_rdata;

endmodule
